// File: rtl/uart_tx_frame.sv
// UART transmit framer: start bit, 8 data bits LSB first, optional parity, 1 or 2 stop bits.
// tx, busy and done are all registered; frame settings are captured when a send is accepted.
module uart_tx_frame #(
  parameter int CLKS_PER_BIT = 5208
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       send,
  input  logic [7:0] data_in,
  input  logic [1:0] parity_type,
  input  logic       parity_bit,
  input  logic       stop2,
  output logic       tx,
  output logic       busy,
  output logic       done
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       data_q;
  logic             par_q;
  logic             par_en_q;
  logic             stop2_q;
  logic             bit_end;

  assign bit_end = (cnt == CNT_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      bit_idx  <= '0;
      data_q   <= '0;
      par_q    <= 1'b0;
      par_en_q <= 1'b0;
      stop2_q  <= 1'b0;
      tx       <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          tx   <= 1'b1;
          busy <= 1'b0;
          if (send) begin
            data_q   <= data_in;
            par_q    <= parity_bit;
            stop2_q  <= stop2;
            par_en_q <= (parity_type == 2'b01) || (parity_type == 2'b10);
            state    <= START;
            cnt      <= '0;
            bit_idx  <= '0;
            tx       <= 1'b0;
            busy     <= 1'b1;
          end
        end
        default: begin
          if (!bit_end) begin
            cnt <= cnt + 1'b1;
          end else begin
            cnt <= '0;
            case (state)
              START: begin
                state   <= DATA;
                bit_idx <= '0;
                tx      <= data_q[0];
              end
              DATA: begin
                if (bit_idx == 3'd7) begin
                  bit_idx <= '0;
                  if (par_en_q) begin
                    state <= PARITY;
                    tx    <= par_q;
                  end else begin
                    state <= STOP;
                    tx    <= 1'b1;
                  end
                end else begin
                  bit_idx <= bit_idx + 3'd1;
                  tx      <= data_q[bit_idx + 3'd1];
                end
              end
              PARITY: begin
                state   <= STOP;
                bit_idx <= '0;
                tx      <= 1'b1;
              end
              STOP: begin
                // bit_idx counts stop periods; a second one is needed only with stop2
                if (stop2_q && (bit_idx == 3'd0)) begin
                  bit_idx <= 3'd1;
                  tx      <= 1'b1;
                end else begin
                  state   <= IDLE;
                  bit_idx <= '0;
                  tx      <= 1'b1;
                  busy    <= 1'b0;
                  done    <= 1'b1;
                end
              end
              default: begin
                state <= IDLE;
                tx    <= 1'b1;
                busy  <= 1'b0;
              end
            endcase
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Scoreboard bench for uart_tx_frame with CLKS_PER_BIT=4: stimulus queues expected frames,
// a negedge monitor checks every cycle of each frame plus the done pulse that ends it.
module tb_uart_tx_frame;

  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       send;
  logic [7:0] data_in;
  logic [1:0] parity_type;
  logic       parity_bit;
  logic       stop2;
  logic       tx;
  logic       busy;
  logic       done;

  uart_tx_frame #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .reset(reset), .send(send), .data_in(data_in),
    .parity_type(parity_type), .parity_bit(parity_bit), .stop2(stop2),
    .tx(tx), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] bits;
    int          nbits;
    bit          b2b;
    int          id;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk = 0;
  int   n_pass = 0;
  int   cyc = 0;
  int   last_done_cyc = -100;
  int   done_cnt = 0;
  int   frames_expected = 0;
  bit   rst_hit = 1'b0;

  always @(posedge clk) cyc++;
  always @(negedge clk) if (done) done_cnt++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, req);
  endtask

  // Called at the negedge of the first frame cycle.
  task automatic check_frame(input exp_t e);
    for (int b = 0; b < e.nbits; b++) begin
      for (int c = 0; c < CPB; c++) begin
        if (!(b == 0 && c == 0)) @(negedge clk);
        if (rst_hit) return;
        chk($sformatf("frame%0d bit%0d cyc%0d {busy,tx}", e.id, b, c), {busy, tx}, {1'b1, e.bits[b]});
      end
    end
    @(negedge clk);
    if (rst_hit) return;
    chk($sformatf("frame%0d end {done,busy,tx}", e.id), {done, busy, tx}, 3'b101);
    last_done_cyc = cyc;
  endtask

  initial begin : monitor
    exp_t e;
    logic prev_busy;
    prev_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset && busy && !prev_busy) begin
        if (exp_q.size() == 0) begin
          chk("unexpected frame start", 1, 0);
        end else begin
          e = exp_q.pop_front();
          if (e.b2b) chk($sformatf("frame%0d gap after done", e.id), cyc - last_done_cyc, 1);
          chk($sformatf("frame%0d done low at start", e.id), done, 0);
          check_frame(e);
        end
      end
      prev_busy = busy;
    end
  end

  task automatic push_exp(input logic [15:0] bits, input int nbits, input bit b2b, input int id,
                          input bit counts);
    exp_t e;
    e.bits = bits; e.nbits = nbits; e.b2b = b2b; e.id = id;
    exp_q.push_back(e);
    if (counts) frames_expected++;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic [1:0] pt, input logic pb,
                            input logic s2, input logic [15:0] bits, input int nbits,
                            input int id, input bit counts);
    @(posedge clk); #1;
    data_in = d; parity_type = pt; parity_bit = pb; stop2 = s2; send = 1'b1;
    push_exp(bits, nbits, 1'b0, id, counts);
    @(posedge clk); #1;
    send = 1'b0;
  endtask

  task automatic wait_done(input string name);
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (done) return;
    end
    chk({name, " done timeout"}, 0, 1);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "timeout");
  end

  initial begin : stim
    reset = 1'b1; send = 1'b0; data_in = 8'h00; parity_type = 2'b00;
    parity_bit = 1'b0; stop2 = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    chk("reset state {tx,busy,done}", {tx, busy, done}, 3'b100);
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1 chk("idle after reset {tx,busy}", {tx, busy}, 2'b10);

    // 0xA5, no parity, 1 stop: 0,1,0,1,0,0,1,0,1,1
    send_frame(8'hA5, 2'b00, 1'b1, 1'b0, 16'b1101001010, 10, 1, 1'b1);
    wait_done("A5");

    // 0x55 even parity, pb=0: 0,1,0,1,0,1,0,1,0,0,1
    send_frame(8'h55, 2'b10, 1'b0, 1'b0, 16'b10010101010, 11, 2, 1'b1);
    wait_done("55 even");

    // 0x55 odd parity, pb=1: parity slot reads 1
    send_frame(8'h55, 2'b01, 1'b1, 1'b0, 16'b11010101010, 11, 3, 1'b1);
    wait_done("55 odd");

    // 0x3C, parity_type=11, two stops: 0,0,0,1,1,1,1,0,0,1,1; parity_bit toggled in flight
    send_frame(8'h3C, 2'b11, 1'b0, 1'b1, 16'b11001111000, 11, 4, 1'b1);
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (i % 3 == 0) parity_bit = ~parity_bit;
    end
    wait_done("3C stop2");

    // Back-to-back with send held: 0x00 then 0xFF
    @(posedge clk); #1;
    data_in = 8'h00; parity_type = 2'b00; stop2 = 1'b0; send = 1'b1;
    push_exp(16'b1000000000, 10, 1'b0, 5, 1'b1);
    push_exp(16'b1111111110, 10, 1'b1, 6, 1'b1);
    @(posedge clk); #1;
    data_in = 8'hFF;
    wait_done("00 b2b");
    @(posedge clk); #1;
    send = 1'b0;
    wait_done("FF b2b");

    // 0x81 even parity pb=0: 0,1,0,0,0,0,0,0,1,0,1; inputs churn while busy
    send_frame(8'h81, 2'b10, 1'b0, 1'b0, 16'b10100000010, 11, 7, 1'b1);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      send = i[0];
      data_in = 8'h3C ^ 8'(i);
      parity_type = 2'(i);
      parity_bit = ~parity_bit;
      stop2 = 1'b1;
    end
    send = 1'b0; stop2 = 1'b0; parity_type = 2'b00;
    wait_done("81 ignore");

    // Reset asserted in the middle of DATA
    send_frame(8'hA5, 2'b00, 1'b0, 1'b0, 16'b1101001010, 10, 8, 1'b0);
    repeat (6) @(posedge clk);
    #3;
    rst_hit = 1'b1;
    reset = 1'b1;
    #1 chk("async reset mid-frame {tx,busy,done}", {tx, busy, done}, 3'b100);
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      chk($sformatf("idle after abort cyc%0d {tx,busy,done}", i), {tx, busy, done}, 3'b100);
    end
    rst_hit = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk("done pulse count", done_cnt, frames_expected);
    chk("scoreboard drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
